// File: rtl/wave_capture.sv
// wave_capture: decimates the wave generator output into a FIFO that the CPU drains over iomem.
// Define WAVE_CAPTURE_TRIG_EN to add the ARMED state and CTRL.TRIGEN rising-edge trigger on wave[0].
module wave_capture #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] wave,
    input  logic        sel,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ARMED = 2'd3
    } state_e;

    logic              ready_q;
    logic [31:0]       rdata_q;
    logic              en_q, en_d;
    logic              oneshot_q, oneshot_d;
    logic [31:0]       div_q, div_d;
    logic [31:0]       presc_q, presc_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    state_e            state_q, state_d;
    logic [31:0]       mem [DEPTH];

    logic              trigen;
    logic              trig_edge;

`ifdef WAVE_CAPTURE_TRIG_EN
    logic trigen_q, trigen_d;
    logic wave0_q;
    assign trigen    = trigen_q;
    assign trig_edge = wave[0] & ~wave0_q;
`else
    assign trigen    = 1'b0;
    assign trig_edge = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    // A new access starts only when ready is low, so a held sel in the ack cycle is ignored.
    logic access, is_write, wr_ctrl, wr_div, rd_data, clr;
    logic full, empty, strobe, push, pop, ovf_set;

    assign access   = sel & ~ready_q;
    assign is_write = |wstrb;
    assign wr_ctrl  = access & is_write & (addr[3:2] == REG_CTRL);
    assign wr_div   = access & is_write & (addr[3:2] == REG_DIV);
    assign rd_data  = access & ~is_write & (addr[3:2] == REG_DATA);
    assign clr      = wr_ctrl & wstrb[0] & wdata[2];

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign strobe   = (state_q == ST_RUN) & en_q & (presc_q == div_q);
    assign push     = strobe & ~full & ~clr;
    assign pop      = rd_data & ~empty;
    assign ovf_set  = strobe & full & ~oneshot_q;

    logic [31:0] status;
    logic [31:0] rd_val;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        status             = '0;
        status[CNT_W-1:0]  = count_q;
        status[16]         = empty;
        status[17]         = full;
        status[18]         = ovf_q;
        status[21:20]      = state_q;

        rd_val = '0;
        case (addr[3:2])
            REG_CTRL:   rd_val = {28'd0, trigen, 1'b0, oneshot_q, en_q};
            REG_DIV:    rd_val = div_q;
            REG_STATUS: rd_val = status;
            REG_DATA:   rd_val = empty ? '0 : mem[rd_ptr_q];
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
`ifdef WAVE_CAPTURE_TRIG_EN
        trigen_d  = trigen_q;
`endif
        if (wr_ctrl && wstrb[0]) begin
            en_d      = wdata[0];
            oneshot_d = wdata[1];
`ifdef WAVE_CAPTURE_TRIG_EN
            trigen_d  = wdata[3];
`endif
        end

        div_d = div_q;
        for (int b = 0; b < 4; b++) begin
            if (wr_div && wstrb[b]) div_d[8*b +: 8] = wdata[8*b +: 8];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (ovf_set) ovf_d = 1'b1;
        end

        // Outside an enabled RUN the prescaler rests at 0, so RUN always starts a fresh period.
        if (state_q != ST_RUN || !en_q || strobe) presc_d = '0;
        else                                      presc_d = presc_q + 32'd1;
        if (wr_div || clr) presc_d = '0;

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en_q) state_d = trigen ? ST_ARMED : ST_RUN;
            ST_ARMED: begin
                if (!en_q)          state_d = ST_IDLE;
                else if (trig_edge) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en_q)                                            state_d = ST_IDLE;
                else if (oneshot_q && strobe && count_d == FULL_CNT)  state_d = ST_DONE;
            end
            ST_DONE:  if (!en_q || clr) state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            div_q     <= '0;
            presc_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state_q   <= ST_IDLE;
`ifdef WAVE_CAPTURE_TRIG_EN
            trigen_q  <= 1'b0;
            wave0_q   <= 1'b0;
`endif
        end else begin
            ready_q   <= access;
            rdata_q   <= (access && !is_write) ? rd_val : '0;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            div_q     <= div_d;
            presc_q   <= presc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
`ifdef WAVE_CAPTURE_TRIG_EN
            trigen_q  <= trigen_d;
            wave0_q   <= wave[0];
`endif
        end
    end

    // NOTE: the sample store has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wave;
    end

    assign rdata = rdata_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed scenarios plus random bus traffic against a queue model.
module tb_wave_capture;
    localparam int DEPTH = 16;
    localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_ARMED = 3;
    localparam logic [1:0] R_CTRL = 2'd0, R_DIV = 2'd1, R_STATUS = 2'd2, R_DATA = 2'd3;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] wave;
    logic        sel;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    int n_chk = 0;
    int n_err = 0;
    int wave_mode = 2;  // 0 counter, 1 random, 2 hold, 3 step by two

    wave_capture #(.DEPTH(16), .CNT_W(5)) dut (
        .clk(clk), .resetn(resetn), .wave(wave), .sel(sel), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, registers as plain variables, evaluated once per clock.
    logic [31:0] mq[$];
    int          m_state;
    bit          m_ready, m_en, m_one, m_trigen, m_ovf, m_wave0;
    logic [31:0] m_rdata, m_div, m_presc;

    always @(posedge clk or negedge resetn) begin : ref_model
        bit acc, wr, clr, strobe, was_full;
        logic [1:0]  r;
        logic [31:0] rd, st;
        int nxt;
        if (!resetn) begin
            mq.delete();
            m_state = S_IDLE; m_ready = 0; m_rdata = 0; m_en = 0; m_one = 0;
            m_trigen = 0; m_ovf = 0; m_wave0 = 0; m_div = 0; m_presc = 0;
        end else begin
            acc      = sel && !m_ready;
            wr       = (wstrb != 4'h0);
            r        = addr[3:2];
            clr      = acc && wr && (r == R_CTRL) && wstrb[0] && wdata[2];
            strobe   = (m_state == S_RUN) && m_en && (m_presc == m_div);
            was_full = (mq.size() == DEPTH);
            st = 32'd0;
            st[4:0]   = 5'(mq.size());
            st[16]    = (mq.size() == 0);
            st[17]    = was_full;
            st[18]    = m_ovf;
            st[21:20] = 2'(m_state);
            rd = 32'd0;
            if (acc && !wr) begin
                case (r)
                    R_CTRL:   rd = {28'd0, m_trigen, 1'b0, m_one, m_en};
                    R_DIV:    rd = m_div;
                    R_STATUS: rd = st;
                    default:  if (mq.size() > 0) rd = mq.pop_front();
                endcase
            end
            if (strobe && !clr) begin
                if (!was_full)   mq.push_back(wave);
                else if (!m_one) m_ovf = 1'b1;
            end
            nxt = m_state;
            case (m_state)
                S_IDLE:  if (m_en) nxt = m_trigen ? S_ARMED : S_RUN;
                S_ARMED: if (!m_en) nxt = S_IDLE; else if (wave[0] && !m_wave0) nxt = S_RUN;
                S_RUN:   if (!m_en) nxt = S_IDLE;
                         else if (m_one && strobe && !clr && mq.size() == DEPTH) nxt = S_DONE;
                default: if (!m_en || clr) nxt = S_IDLE;
            endcase
            if (m_state != S_RUN || !m_en || strobe) m_presc = 0;
            else                                     m_presc = m_presc + 1;
            if (acc && wr && r == R_CTRL && wstrb[0]) begin
                m_en  = wdata[0];
                m_one = wdata[1];
`ifdef WAVE_CAPTURE_TRIG_EN
                m_trigen = wdata[3];
`endif
            end
            if (acc && wr && r == R_DIV) begin
                for (int b = 0; b < 4; b++) if (wstrb[b]) m_div[8*b +: 8] = wdata[8*b +: 8];
                m_presc = 0;
            end
            if (clr) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_presc = 0;
            end
            m_wave0 = wave[0];
            m_state = nxt;
            m_ready = acc;
            m_rdata = (acc && !wr) ? rd : 32'd0;
        end
    end

    // Cycle-by-cycle comparison of the bus outputs against the model.
    initial forever begin
        @(negedge clk);
        if (resetn === 1'b1) begin
            check("ready", {31'd0, ready}, {31'd0, m_ready});
            if (m_ready) check("rdata", rdata, m_rdata);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (wave_mode)
            0:       wave = wave + 32'd1;
            1:       wave = $urandom;
            3:       wave = wave + 32'd2;
            default: ;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic bus(input bit wr, input logic [1:0] r, input logic [31:0] d,
                       input logic [3:0] strb, output logic [31:0] rd);
        int budget;
        @(posedge clk); #1;
        sel   = 1'b1;
        addr  = {28'd0, r, 2'b00};
        wstrb = wr ? strb : 4'h0;
        wdata = d;
        @(posedge clk); #1;
        budget = 0;
        while (!ready && budget < 8) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ack_latency", 32'(budget), 32'd0);
        rd = rdata;
        @(posedge clk); #1;
        check("ack_width", {31'd0, ready}, 32'd0);
        sel   = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, r, d, 4'hF, dummy);
    endtask

    task automatic bus_rd(input logic [1:0] r, output logic [31:0] rd);
        bus(1'b0, r, 32'd0, 4'h0, rd);
    endtask

    initial begin
        logic [31:0] v, prev, head, d;
        logic [3:0]  s;
        int n, op;
        bit found;

        resetn = 1'b0; sel = 1'b0; wstrb = 4'h0; addr = 32'd0; wdata = 32'd0; wave = 32'd0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        // Reset values
        bus_rd(R_CTRL, v);   check("t1_ctrl", v, 32'd0);
        bus_rd(R_DIV, v);    check("t1_div", v, 32'd0);
        bus_rd(R_STATUS, v); check("t1_status", v, 32'h0001_0000);
        bus_rd(R_DATA, v);   check("t1_data", v, 32'd0);

        // Decimation by four on a counting input
        wave_mode = 0;
        bus_wr(R_DIV, 32'd3);
        bus_wr(R_CTRL, 32'd1);
        repeat (40) @(posedge clk);
        bus_wr(R_CTRL, 32'd0);
        bus_rd(R_STATUS, v);
        n = int'(v[4:0]);
        check("t2_count_range", {31'd0, (n >= 9 && n <= 12)}, 32'd1);
        prev = 32'd0;
        for (int i = 0; i < n; i++) begin
            bus_rd(R_DATA, v);
            if (i > 0) check("t2_step", v - prev, 32'd4);
            prev = v;
            bus_rd(R_STATUS, v);
            check("t2_count_dec", {27'd0, v[4:0]}, 32'(n - 1 - i));
        end
        bus_rd(R_DATA, v); check("t2_empty_data", v, 32'd0);

        // One-shot fill
        bus_wr(R_CTRL, 32'h4);
        bus_wr(R_DIV, 32'd0);
        bus_wr(R_CTRL, 32'h3);
        repeat (30) @(posedge clk);
        bus_rd(R_STATUS, v); check("t3_status_full_done", v, 32'h0022_0010);
        for (int i = 0; i < DEPTH; i++) begin
            bus_rd(R_DATA, v);
            if (i > 0) check("t3_step", v - prev, 32'd1);
            prev = v;
        end
        bus_rd(R_STATUS, v); check("t3_status_drained", v, 32'h0021_0000);
        bus_wr(R_CTRL, 32'd0);

        // Continuous capture into a full FIFO
        bus_wr(R_CTRL, 32'd1);
        repeat (20) @(posedge clk);
        bus_wr(R_CTRL, 32'd0);
        bus_rd(R_STATUS, v); check("t4_status_ovf", v, 32'h0006_0010);
        for (int i = 0; i < DEPTH; i++) begin
            bus_rd(R_DATA, v);
            if (i > 0) check("t4_step", v - prev, 32'd1);
            prev = v;
        end
        bus_rd(R_STATUS, v); check("t4_status_empty_ovf", v, 32'h0005_0000);
        bus_wr(R_CTRL, 32'h4);
        bus_rd(R_STATUS, v); check("t4_status_clr", v, 32'h0001_0000);

        // Push and pop of the last entry on the same edge
        bus_wr(R_DIV, 32'd5);
        bus_wr(R_CTRL, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (m_state == S_RUN && mq.size() == 1 && m_presc == m_div) found = 1'b1;
        end
        check("t5_align", {31'd0, found}, 32'd1);
        if (found) begin
            head  = mq[0];
            sel   = 1'b1;
            addr  = {28'd0, R_DATA, 2'b00};
            wstrb = 4'h0;
            @(posedge clk); #1;
            check("t5_ready", {31'd0, ready}, 32'd1);
            check("t5_old_head", rdata, head);
            @(posedge clk); #1;
            sel = 1'b0;
            bus_rd(R_STATUS, v);
            check("t5_count_one", {27'd0, v[4:0]}, 32'd1);
        end

        // Reset during an acknowledge
        @(posedge clk); #1;
        sel = 1'b1; addr = {28'd0, R_DIV, 2'b00}; wstrb = 4'h0;
        @(posedge clk); #1;
        check("t5_ready_pre", {31'd0, ready}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t5_rst_ready", {31'd0, ready}, 32'd0);
        check("t5_rst_rdata", rdata, 32'd0);
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        bus_rd(R_STATUS, v); check("t5_post_status", v, 32'h0001_0000);
        bus_rd(R_CTRL, v);   check("t5_post_ctrl", v, 32'd0);
        bus_rd(R_DIV, v);    check("t5_post_div", v, 32'd0);

`ifdef WAVE_CAPTURE_TRIG_EN
        // Rising-edge trigger on wave[0]
        wave_mode = 2;
        @(posedge clk); #2 wave = 32'd0;
        bus_wr(R_DIV, 32'd2);
        bus_wr(R_CTRL, 32'h9);
        repeat (10) @(posedge clk);
        bus_rd(R_STATUS, v); check("t6_armed", v, 32'h0031_0000);
        @(posedge clk); #2;
        wave = 32'd1;
        wave_mode = 3;
        repeat (7) @(posedge clk);
        bus_wr(R_CTRL, 32'd0);
        bus_rd(R_DATA, v); check("t6_first_sample", v, 32'd7);
        bus_wr(R_CTRL, 32'h4);
`endif

        // Random traffic against the model
        wave_mode = 1;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            s  = 4'($urandom_range(1, 15));
            case (op)
                0, 1: begin
                    d = 32'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
                    bus(1'b1, R_CTRL, d, s, v);
                end
                2:       bus(1'b1, R_DIV, 32'($urandom_range(0, 3)), s, v);
                3:       bus(1'b1, 2'($urandom_range(2, 3)), $urandom, s, v);
                default: bus_rd(2'($urandom_range(0, 3)), v);
            endcase
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
